// File: rtl/arm_pkg.sv
// Shared types and defaults for the memory stage of the ARM pipeline.
package arm_pkg;

    localparam int unsigned ADDR_BASE_DEF = 1024;
    localparam int unsigned MEM_AW_DEF    = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } mem_state_e;

    // One MEM/WB pipeline register slot.
    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] mem;
    } wb_bundle_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB output register; inserts a bubble (write-back and load flag cleared)
// while the memory stage is frozen.
module mem_wb_reg
    import arm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  wb_bundle_t d,
    output wb_bundle_t q
);

    wb_bundle_t q_d, q_q;

    always_comb begin
        q_d = d;
        if (freeze) begin
            q_d          = q_q;
            q_d.wb_en    = 1'b0;
            q_d.mem_r_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= '0;
        else      q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues a held request/ack transaction to an external data
// memory, stalls the pipeline meanwhile, and registers results toward WB.
module mem_stage
    import arm_pkg::*;
#(
    parameter int unsigned ADDR_BASE = ADDR_BASE_DEF,
    parameter int unsigned MEM_AW    = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic              WB_EN_in,
    input  logic [3:0]        Dest_in,
    input  logic [31:0]       ALU_result,
    input  logic [31:0]       Val_Rm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              freeze,
    output logic              WB_EN,
    output logic              MEM_R_EN_out,
    output logic [3:0]        Dest,
    output logic [31:0]       ALU_result_out,
    output logic [31:0]       MEM_result
);

    localparam logic [31:0] BASE = 32'(ADDR_BASE);

    mem_state_e        state_d, state_q;
    logic              we_d, we_q;
    logic [MEM_AW-1:0] addr_d, addr_q;
    logic [31:0]       wdata_d, wdata_q;
    logic [31:0]       rdata_d, rdata_q;

    logic [31:0] offset, word_off;
    logic        in_range, mem_op;

    assign offset   = ALU_result - BASE;
    assign word_off = offset >> 2;
    // Below the base the subtraction wraps, so the lower bound is checked separately.
    assign in_range = (ALU_result >= BASE) && (word_off < (32'd1 << MEM_AW));
    assign mem_op   = MEM_R_EN | MEM_W_EN;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    we_d    = MEM_W_EN & ~MEM_R_EN;
                    addr_d  = word_off[MEM_AW-1:0];
                    wdata_d = Val_Rm;
                    rdata_d = '0;
                    state_d = in_range ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    if (!we_q) rdata_d = mem_rdata;
                end
            end
            // Single release cycle: the frozen instruction leaves before it can re-issue.
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_req   = (state_q == S_ACCESS);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign freeze    = ((state_q == S_IDLE) & mem_op) | (state_q == S_ACCESS);

    wb_bundle_t wb_d, wb_q;

    always_comb begin
        wb_d          = '0;
        wb_d.wb_en    = WB_EN_in;
        wb_d.mem_r_en = MEM_R_EN;
        wb_d.dest     = Dest_in;
        wb_d.alu      = ALU_result;
        wb_d.mem      = rdata_q;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign WB_EN          = wb_q.wb_en;
    assign MEM_R_EN_out   = wb_q.mem_r_en;
    assign Dest           = wb_q.dest;
    assign ALU_result_out = wb_q.alu;
    assign MEM_result     = wb_q.mem;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage with a latency-programmable memory responder.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        MEM_R_EN = 1'b0, MEM_W_EN = 1'b0, WB_EN_in = 1'b0;
    logic [3:0]  Dest_in = '0;
    logic [31:0] ALU_result = '0, Val_Rm = '0;
    logic        mem_req, mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        freeze, WB_EN, MEM_R_EN_out;
    logic [3:0]  Dest;
    logic [31:0] ALU_result_out, MEM_result;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN_in(WB_EN_in),
        .Dest_in(Dest_in), .ALU_result(ALU_result), .Val_Rm(Val_Rm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .freeze(freeze), .WB_EN(WB_EN), .MEM_R_EN_out(MEM_R_EN_out),
        .Dest(Dest), .ALU_result_out(ALU_result_out), .MEM_result(MEM_result)
    );

    typedef struct {
        logic        wb;
        logic        mr;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] mres;
        logic        chk_mres;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory responder: acks on the ack_dly-th cycle of a request, records what it saw.
    int          ack_dly = 1;
    logic [31:0] rd_val = '0;
    logic        stray_ack = 1'b0;
    int          req_cnt = 0, total_req = 0, unstable = 0;
    logic        seen_we = 1'b0;
    logic [5:0]  seen_addr = '0;
    logic [31:0] seen_wdata = '0;

    always @(negedge clk) begin
        if (mem_req) begin
            if (req_cnt == 0) begin
                seen_we = mem_we; seen_addr = mem_addr; seen_wdata = mem_wdata;
            end else if ({mem_we, mem_addr, mem_wdata} != {seen_we, seen_addr, seen_wdata}) begin
                unstable++;
            end
            req_cnt++;
            total_req++;
            mem_ack   = (req_cnt == ack_dly);
            mem_rdata = mem_ack ? rd_val : 32'h0;
        end else begin
            req_cnt   = 0;
            mem_ack   = stray_ack;
            mem_rdata = stray_ack ? 32'hBAD0BAD0 : 32'h0;
        end
    end

    // Acts as the upstream stage: holds the instruction while frozen, pushes
    // the expected WB slot when it is accepted, then pops and compares it.
    task automatic run_instr(input string tag, input logic r, input logic w, input logic wb,
                             input logic [3:0] dest, input logic [31:0] alu, input logic [31:0] rm,
                             input int dly, input logic [31:0] rd, input int exp_frz,
                             input int exp_req, input logic exp_we, input logic [5:0] exp_addr,
                             input logic [31:0] exp_mres);
        int   frz = 0;
        int   req0;
        int   unst0;
        logic done = 1'b0;
        exp_t e;
        ack_dly = dly; rd_val = rd; req0 = total_req; unst0 = unstable;
        MEM_R_EN = r; MEM_W_EN = w; WB_EN_in = wb; Dest_in = dest; ALU_result = alu; Val_Rm = rm;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!freeze) sb.push_back('{wb, r, dest, alu, exp_mres, r});
            else         frz++;
            @(posedge clk); #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_wb"},   {31'd0, WB_EN},        {31'd0, e.wb});
                chk({tag, "_mr"},   {31'd0, MEM_R_EN_out}, {31'd0, e.mr});
                chk({tag, "_dest"}, {28'd0, Dest},         {28'd0, e.dest});
                chk({tag, "_alu"},  ALU_result_out,        e.alu);
                if (e.chk_mres) chk({tag, "_mres"}, MEM_result, e.mres);
                done = 1'b1;
            end else begin
                chk({tag, "_bubble"}, {30'd0, WB_EN, MEM_R_EN_out}, 32'd0);
            end
            @(negedge clk);
            if (done) break;
        end
        if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; WB_EN_in = 1'b0;
        chk({tag, "_freeze_cycles"}, 32'(frz), 32'(exp_frz));
        chk({tag, "_req_cycles"}, 32'(total_req - req0), 32'(exp_req));
        chk({tag, "_req_stable"}, 32'(unstable - unst0), 32'd0);
        if (exp_req > 0) begin
            chk({tag, "_we"},    {31'd0, seen_we},   {31'd0, exp_we});
            chk({tag, "_addr"},  {26'd0, seen_addr}, {26'd0, exp_addr});
            chk({tag, "_wdata"}, seen_wdata,         rm);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req",    {31'd0, mem_req},      32'd0);
        chk("rst_we",     {31'd0, mem_we},       32'd0);
        chk("rst_freeze", {31'd0, freeze},       32'd0);
        chk("rst_wb",     {31'd0, WB_EN},        32'd0);
        chk("rst_mr",     {31'd0, MEM_R_EN_out}, 32'd0);
        chk("rst_dest",   {28'd0, Dest},         32'd0);
        chk("rst_alu",    ALU_result_out,        32'd0);
        chk("rst_mres",   MEM_result,            32'd0);
        @(negedge clk);
        rst = 1'b1;

        // tag          r     w     wb    dest   alu       rm            dly rd            frz req we    addr  mres
        run_instr("add",  1'b0, 1'b0, 1'b1, 4'd3,  32'h55,   32'h0,        1, 32'h0,         0, 0, 1'b0, 6'd0, 32'h0);
        run_instr("ld_b2b", 1'b1, 1'b0, 1'b1, 4'd4, 32'd1028, 32'h0,      1, 32'hCAFEF00D,  2, 1, 1'b0, 6'd1, 32'hCAFEF00D);
        run_instr("ld_slow", 1'b1, 1'b0, 1'b1, 4'd5, 32'd1028, 32'h0,     2, 32'hDEADBEEF,  3, 2, 1'b0, 6'd1, 32'hDEADBEEF);
        run_instr("st",   1'b0, 1'b1, 1'b0, 4'd6,  32'd1024, 32'h12345678, 1, 32'hFFFFFFFF, 2, 1, 1'b1, 6'd0, 32'h0);
        run_instr("both", 1'b1, 1'b1, 1'b1, 4'd7,  32'd1032, 32'hAAAA5555, 1, 32'h0BADCAFE,  2, 1, 1'b0, 6'd2, 32'h0BADCAFE);
        run_instr("oor_lo", 1'b1, 1'b0, 1'b1, 4'd8, 32'd1000, 32'h0,      1, 32'h11111111,  1, 0, 1'b0, 6'd0, 32'h0);
        run_instr("top",  1'b1, 1'b0, 1'b1, 4'd9,  32'd1279, 32'h0,        1, 32'h76543210,  2, 1, 1'b0, 6'd63, 32'h76543210);
        run_instr("oor_hi", 1'b1, 1'b0, 1'b1, 4'd10, 32'd1280, 32'h0,     1, 32'h22222222,  1, 0, 1'b0, 6'd0, 32'h0);
        run_instr("st_oor", 1'b0, 1'b1, 1'b0, 4'd11, 32'd4,  32'h33333333, 1, 32'h0,        1, 0, 1'b0, 6'd0, 32'h0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, d;
            int          dl;
            a  = 32'd1024 + 32'($urandom_range(0, 255));
            d  = $urandom;
            dl = int'($urandom_range(1, 3));
            run_instr("rnd_ld", 1'b1, 1'b0, 1'b1, 4'(i), a, 32'h0, dl, d, 1 + dl, dl, 1'b0,
                      6'((a - 32'd1024) >> 2), d);
        end

        // Reset in the middle of a transaction, then a stray ack.
        ack_dly = 100;
        MEM_R_EN = 1'b1; WB_EN_in = 1'b1; Dest_in = 4'd12; ALU_result = 32'd1040;
        @(negedge clk); #1;
        chk("mid_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        MEM_R_EN = 1'b0; WB_EN_in = 1'b0;
        #1;
        chk("mid_rst_req",    {31'd0, mem_req}, 32'd0);
        chk("mid_rst_freeze", {31'd0, freeze},  32'd0);
        chk("mid_rst_dest",   {28'd0, Dest},    32'd0);
        chk("mid_rst_alu",    ALU_result_out,   32'd0);
        chk("mid_rst_mres",   MEM_result,       32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("stray_req",  {31'd0, mem_ack & mem_req}, 32'd0);
        chk("stray_ack_seen", {31'd0, mem_ack}, 32'd1);
        chk("stray_mres", MEM_result, 32'd0);
        chk("stray_wb",   {31'd0, WB_EN}, 32'd0);
        stray_ack = 1'b0;
        repeat (2) @(negedge clk);

        run_instr("post_ld", 1'b1, 1'b0, 1'b1, 4'd13, 32'd1036, 32'h0, 1, 32'h5A5A5A5A, 2, 1, 1'b0, 6'd3, 32'h5A5A5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
